// File: rtl/br_lite_ni.sv
// BrLite local-port network interface.
// TX: PE requests become br_data_t flits driven to the router's local input
//     with a 4-phase req/ack handshake, throttled by the router's local_busy.
// RX: answers the router's local-output requests with a one-cycle ack and
//     buffers delivered flits in a small FIFO for the PE.
// Optional feature macro: BRLITE_NI_MON_DROP_EN
//     When defined, incoming MON flits are acked even into a full FIFO and are
//     never buffered. When undefined, MON flits are buffered like any other.

package br_lite_pkg;

    localparam int BR_PAYLOAD_W = 8;
    localparam int BR_ID_W      = 5;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_MON   = 2'd2,
        BR_SVC_CLEAR = 2'd3
    } br_service_t;

    typedef struct packed {
        logic [15:0]             seq_source;
        logic [15:0]             seq_target;
        br_service_t             service;
        logic [BR_PAYLOAD_W-1:0] payload;
        logic [BR_ID_W-1:0]      id;
    } br_data_t;

    localparam int BR_DATA_W = $bits(br_data_t);

endpackage

module br_lite_ni
    import br_lite_pkg::*;
#(
    parameter logic [15:0] SEQ_ADDRESS = 16'h0,
    parameter int          RX_DEPTH    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    input  br_service_t             tx_service_i,
    input  logic [15:0]             tx_target_i,
    input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
    output logic                    tx_err_o,
    input  logic                    local_busy_i,
    output br_data_t                flit_o,
    output logic                    req_o,
    input  logic                    ack_i,
    input  br_data_t                flit_i,
    input  logic                    req_i,
    output logic                    ack_o,
    output logic                    rx_valid_o,
    input  logic                    rx_ready_i,
    output br_data_t                rx_flit_o
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_REQ     = 2'd1,
        TX_RELEASE = 2'd2
    } tx_state_t;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    tx_state_t          tx_state_r;
    br_data_t           tx_flit_r;
    logic               req_r;
    logic               tx_err_r;
    logic [BR_ID_W-1:0] id_cnt_r;
    logic               tx_ready_s;
    logic               tx_accept_s;

    // Ready only in IDLE, while the router is not busy and has dropped its ack.
    always_comb begin
        tx_ready_s = 1'b0;
        if ((tx_state_r == TX_IDLE) && !rst_i) begin
            tx_ready_s = !local_busy_i && !ack_i;
        end else begin
            tx_ready_s = 1'b0;
        end
    end

    assign tx_accept_s = tx_valid_i && tx_ready_s;

    // TX handshake FSM: latch the flit on accept, hold req until ack, wait for ack release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_r <= TX_IDLE;
            tx_flit_r  <= br_data_t'({BR_DATA_W{1'b0}});
            req_r      <= 1'b0;
            tx_err_r   <= 1'b0;
            id_cnt_r   <= {BR_ID_W{1'b0}};
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_err_r <= 1'b0;
                    if (tx_accept_s) begin
                        if (tx_service_i == BR_SVC_CLEAR) begin
                            // CLEAR cannot be injected: flag it and keep the id.
                            tx_err_r <= 1'b1;
                        end else begin
                            tx_flit_r.seq_source <= SEQ_ADDRESS;
                            tx_flit_r.seq_target <= tx_target_i;
                            tx_flit_r.service    <= tx_service_i;
                            tx_flit_r.payload    <= tx_payload_i;
                            tx_flit_r.id         <= id_cnt_r;
                            req_r                <= 1'b1;
                            tx_state_r           <= TX_REQ;
                        end
                    end
                end
                TX_REQ: begin
                    tx_err_r <= 1'b0;
                    // local_busy is deliberately ignored here: a pending request is never aborted.
                    if (ack_i) begin
                        req_r      <= 1'b0;
                        id_cnt_r   <= id_cnt_r + BR_ID_W'(1'b1);
                        tx_state_r <= TX_RELEASE;
                    end
                end
                TX_RELEASE: begin
                    tx_err_r <= 1'b0;
                    req_r    <= 1'b0;
                    if (!ack_i) begin
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    req_r      <= 1'b0;
                    tx_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready_o = tx_ready_s;
    assign tx_err_o   = tx_err_r;
    assign req_o      = req_r;
    assign flit_o     = tx_flit_r;

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    br_data_t         rx_mem_r [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] rx_count_r;
    logic             ack_r;
    logic             full_s;
    logic             capture_s;
    logic             push_s;
    logic             pop_s;

    // Capture decision, evaluated against the registered count (no bypass).
    always_comb begin
        full_s    = (rx_count_r == CNT_W'(RX_DEPTH));
        capture_s = 1'b0;
        push_s    = 1'b0;
        pop_s     = (rx_count_r != {CNT_W{1'b0}}) && rx_ready_i;
        if (req_i && !ack_r) begin
`ifdef BRLITE_NI_MON_DROP_EN
            if (flit_i.service == BR_SVC_MON) begin
                capture_s = 1'b1;
                push_s    = 1'b0;
            end else begin
                capture_s = !full_s;
                push_s    = !full_s;
            end
`else
            capture_s = !full_s;
            push_s    = !full_s;
`endif
        end else begin
            capture_s = 1'b0;
            push_s    = 1'b0;
        end
    end

    // One-cycle ack per captured flit; ack high masks a lingering req.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= capture_s;
        end
    end

    // RX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem_r[i] <= br_data_t'({BR_DATA_W{1'b0}});
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            rx_count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                rx_mem_r[wr_ptr_r] <= flit_i;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_W'(1'b1);
                2'b01:   rx_count_r <= rx_count_r - CNT_W'(1'b1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    assign ack_o      = ack_r;
    assign rx_valid_o = (rx_count_r != {CNT_W{1'b0}});
    assign rx_flit_o  = rx_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_br_lite_ni.sv
// Self-checking bench for br_lite_ni: table-driven TX requests, hand-written
// corner sequences (busy throttle, id wrap, full FIFO, reset mid-transfer) and
// a randomized RX phase checked against a queue-based reference model.

module tb_br_lite_ni;
    import br_lite_pkg::*;

    localparam logic [15:0] SEQ   = 16'h0005;
    localparam int          DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    br_service_t tx_service_i;
    logic [15:0] tx_target_i;
    logic [7:0]  tx_payload_i;
    logic        tx_err_o;
    logic        local_busy_i;
    br_data_t    flit_o;
    logic        req_o;
    logic        ack_i;
    br_data_t    flit_i;
    logic        req_i;
    logic        ack_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    br_data_t    rx_flit_o;

    br_lite_ni #(.SEQ_ADDRESS(SEQ), .RX_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_service_i(tx_service_i), .tx_target_i(tx_target_i),
        .tx_payload_i(tx_payload_i), .tx_err_o(tx_err_o),
        .local_busy_i(local_busy_i), .flit_o(flit_o), .req_o(req_o), .ack_i(ack_i),
        .flit_i(flit_i), .req_i(req_i), .ack_o(ack_o),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_flit_o(rx_flit_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int errors   = 0;
    int model_id = 0;   // ids handed out so far, modulo 32

    typedef struct {
        br_service_t svc;
        logic [15:0] tgt;
        logic [7:0]  pay;
        int          ack_cycles;
        bit          busy_mid;
        bit          exp_err;
    } tx_vec_t;

    tx_vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic br_data_t rand_flit();
        br_data_t f;
        f.seq_source = 16'($urandom);
        f.seq_target = 16'($urandom);
        f.service    = ($urandom_range(0, 1) == 1) ? BR_SVC_ALL : BR_SVC_TGT;
        f.payload    = 8'($urandom);
        f.id         = 5'($urandom);
        return f;
    endfunction

    // One PE request plus the router's ack response of ack_cycles cycles.
    task automatic do_send(input br_service_t svc, input logic [15:0] tgt, input logic [7:0] pay,
                           input int ack_cycles, input bit busy_mid, input bit exp_err);
        br_data_t exp;
        tx_valid_i   = 1'b1;
        tx_service_i = svc;
        tx_target_i  = tgt;
        tx_payload_i = pay;
        #1;
        check("tx_ready_idle", 64'(tx_ready_o), 64'd1);
        check("req_before_accept", 64'(req_o), 64'd0);
        tick();
        tx_valid_i = 1'b0;
        check("tx_err_pulse", 64'(tx_err_o), 64'(exp_err));
        if (exp_err) begin
            check("req_after_clear", 64'(req_o), 64'd0);
            tick();
            check("tx_err_one_cycle", 64'(tx_err_o), 64'd0);
            check("req_after_clear2", 64'(req_o), 64'd0);
            check("tx_ready_after_clear", 64'(tx_ready_o), 64'd1);
        end else begin
            exp.seq_source = SEQ;
            exp.seq_target = tgt;
            exp.service    = svc;
            exp.payload    = pay;
            exp.id         = 5'(model_id);
            check("req_rise", 64'(req_o), 64'd1);
            check("flit", 64'(flit_o), 64'(exp));
            local_busy_i = busy_mid;
            tick();
            check("req_hold", 64'(req_o), 64'd1);
            check("flit_stable", 64'(flit_o), 64'(exp));
            ack_i = 1'b1;
            tick();
            check("req_drop", 64'(req_o), 64'd0);
            for (int k = 1; k < ack_cycles; k++) begin
                check("tx_ready_ack_high", 64'(tx_ready_o), 64'd0);
                tick();
                check("req_low_ack", 64'(req_o), 64'd0);
            end
            ack_i        = 1'b0;
            local_busy_i = 1'b0;
            #1;
            check("tx_ready_release", 64'(tx_ready_o), 64'd0);
            tick();
            check("tx_ready_back", 64'(tx_ready_o), 64'd1);
            model_id = (model_id + 1) % 32;
        end
    endtask

    // Router pushes f and expects the single-cycle ack right after the edge.
    task automatic rx_push(input br_data_t f, input string name);
        flit_i = f;
        req_i  = 1'b1;
        tick();
        check(name, 64'(ack_o), 64'd1);
        req_i = 1'b0;
        tick();
        check("rx_ack_single", 64'(ack_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        br_data_t fl[5];
        br_data_t q[$];
        br_data_t held;
        bit       exp_ack;
        bit       pop_pend;
        bit       ok;
        bit       drain;

        rst_i = 1'b1; tx_valid_i = 1'b0; tx_service_i = BR_SVC_ALL; tx_target_i = 16'h0;
        tx_payload_i = 8'h0; local_busy_i = 1'b0; ack_i = 1'b0; flit_i = rand_flit();
        req_i = 1'b0; rx_ready_i = 1'b0;

        vecs[0] = '{BR_SVC_TGT,   16'd3,  8'hAB, 3, 1'b0, 1'b0};
        vecs[1] = '{BR_SVC_ALL,   16'd7,  8'h11, 1, 1'b0, 1'b0};
        vecs[2] = '{BR_SVC_CLEAR, 16'd9,  8'h22, 1, 1'b0, 1'b1};
        vecs[3] = '{BR_SVC_MON,   16'd12, 8'h33, 1, 1'b0, 1'b0};
        vecs[4] = '{BR_SVC_TGT,   16'hFFFF, 8'hFF, 2, 1'b1, 1'b0};
        vecs[5] = '{BR_SVC_ALL,   16'h0,  8'h00, 2, 1'b0, 1'b0};

        // Reset state
        repeat (2) tick();
        check("rst_tx_ready", 64'(tx_ready_o), 64'd0);
        check("rst_tx_err", 64'(tx_err_o), 64'd0);
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_ack", 64'(ack_o), 64'd0);
        check("rst_rx_valid", 64'(rx_valid_o), 64'd0);
        check("rst_flit", 64'(flit_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Table-driven TX requests
        for (int i = 0; i < 6; i++) begin
            do_send(vecs[i].svc, vecs[i].tgt, vecs[i].pay, vecs[i].ack_cycles,
                    vecs[i].busy_mid, vecs[i].exp_err);
        end

        // Busy throttle: ten cycles of refusal, accept as soon as busy drops
        local_busy_i = 1'b1; tx_valid_i = 1'b1; tx_service_i = BR_SVC_TGT;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("busy_ready", 64'(tx_ready_o), 64'd0);
            check("busy_req", 64'(req_o), 64'd0);
            tick();
        end
        local_busy_i = 1'b0;
        do_send(BR_SVC_TGT, 16'h0042, 8'h5C, 1, 1'b0, 1'b0);

        // Id wrap: enough sends to pass 31 -> 0
        for (int i = 0; i < 36; i++) begin
            do_send((i % 2 == 0) ? BR_SVC_TGT : BR_SVC_ALL, 16'(i), 8'(i * 7), 1, 1'b0, 1'b0);
        end

        // RX fill to full, fifth request stalls until a pop frees space
        for (int i = 0; i < 5; i++) fl[i] = rand_flit();
        rx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) rx_push(fl[i], "rx_ack_fill");
        flit_i = fl[4];
        req_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rx_full_noack", 64'(ack_o), 64'd0);
        end
        check("rx_full_valid", 64'(rx_valid_o), 64'd1);
        rx_ready_i = 1'b1;
        #1;
        check("rx_pop0", 64'(rx_flit_o), 64'(fl[0]));
        tick();
        rx_ready_i = 1'b0;
        check("rx_noack_pop_edge", 64'(ack_o), 64'd0);
        tick();
        check("rx_resume_ack", 64'(ack_o), 64'd1);
        req_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            rx_ready_i = 1'b1;
            #1;
            check("rx_pop_order", 64'(rx_flit_o), 64'(fl[i]));
            tick();
        end
        rx_ready_i = 1'b0;
        check("rx_empty", 64'(rx_valid_o), 64'd0);
        check("rx_no_dup_ack", 64'(ack_o), 64'd0);

        // Randomized RX traffic against a queue model
        exp_ack = 1'b0; pop_pend = 1'b0; ok = 1'b0; held = rand_flit();
        for (int cyc = 0; cyc < 400; cyc++) begin
            drain = (cyc >= 300);
            check("rnd_ack", 64'(ack_o), 64'(exp_ack));
            if (pop_pend && q.size() > 0) void'(q.pop_front());
            pop_pend = 1'b0;
            if (exp_ack) q.push_back(held);
            check("rnd_rx_valid", 64'(rx_valid_o), 64'(q.size() != 0));
            if (drain && q.size() == 0 && !(req_i && !exp_ack)) begin
                ok    = 1'b1;
                req_i = 1'b0;
                break;
            end
            if (!req_i || exp_ack) begin
                if (!drain && $urandom_range(0, 1) == 1) begin
                    held   = rand_flit();
                    flit_i = held;
                    req_i  = 1'b1;
                end else begin
                    req_i = 1'b0;
                end
            end
            rx_ready_i = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (rx_valid_o && rx_ready_i && q.size() > 0) begin
                check("rnd_order", 64'(rx_flit_o), 64'(q[0]));
                pop_pend = 1'b1;
            end
            exp_ack = req_i && !exp_ack && (q.size() < DEPTH);
            tick();
        end
        if (!ok) check("rnd_drain_timeout", 64'd0, 64'd1);
        rx_ready_i = 1'b0;
        tick();

`ifdef BRLITE_NI_MON_DROP_EN
        // MON into a full FIFO is acked and discarded
        for (int i = 0; i < 4; i++) begin
            fl[i] = rand_flit();
            rx_push(fl[i], "mon_fill_ack");
        end
        held = rand_flit();
        held.service = BR_SVC_MON;
        rx_push(held, "mon_ack_full");
        for (int i = 0; i < 4; i++) begin
            rx_ready_i = 1'b1;
            #1;
            check("mon_pop_order", 64'(rx_flit_o), 64'(fl[i]));
            tick();
        end
        rx_ready_i = 1'b0;
        check("mon_never_buffered", 64'(rx_valid_o), 64'd0);
`endif

        // Reset during TX_REQ with two flits buffered
        rx_push(rand_flit(), "rst_setup_push");
        tx_valid_i = 1'b1; tx_service_i = BR_SVC_TGT; tx_target_i = 16'h1; tx_payload_i = 8'h1;
        tick();
        tx_valid_i = 1'b0;
        check("rst_setup_req", 64'(req_o), 64'd1);
        flit_i = rand_flit();
        req_i  = 1'b1;
        tick();
        check("rst_setup_ack", 64'(ack_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_req", 64'(req_o), 64'd0);
        check("rst_mid_ack", 64'(ack_o), 64'd0);
        check("rst_mid_rx_valid", 64'(rx_valid_o), 64'd0);
        check("rst_mid_flit", 64'(flit_o), 64'd0);
        req_i    = 1'b0;
        model_id = 0;
        tick();
        rst_i = 1'b0;
        tick();
        do_send(BR_SVC_TGT, 16'h0009, 8'h5A, 1, 1'b0, 1'b0);
        check("rst_rx_still_empty", 64'(rx_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
